// File: rtl/drum_step_sequencer.sv
// Drum pattern store and trigger generator, driven by the step counter's index
// and advance strobe; one on/off bit per track per step, fixed-length triggers.
module drum_step_sequencer #(
  parameter int TRACKS   = 4,
  parameter int STEPS    = 8,
  parameter int STEP_W   = 3,
  parameter int TRK_W    = 2,
  parameter int TRIG_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] step_i,
  input  logic              step_adv_i_n,
  input  logic              start_i,
  input  logic [TRACKS-1:0] mute_i,
  input  logic [TRK_W-1:0]  edit_track_i,
  input  logic [STEP_W-1:0] edit_step_i,
  input  logic              edit_toggle_i,
  input  logic              edit_clear_i,
  output logic [TRACKS-1:0] trig_o,
  output logic              beat_o,
  output logic [STEPS-1:0]  row_o
);

  localparam int TMR_W = $clog2(TRIG_LEN + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TRIG_LEN);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic                           adv_q;
  logic                           beat_q, beat_d;
  logic [TRACKS-1:0][STEPS-1:0]   pattern_q, pattern_d, toggle_mask;
  logic [TRACKS-1:0][TMR_W-1:0]   timer_q, timer_d;
  logic [TRACKS-1:0]              load;
  logic [TRACKS-1:0]              edit_trk_dec;
  logic [STEPS-1:0]               step_dec, edit_step_dec;
  logic                           fire;

  // adv_q and start_i collapse into one fire, so a coincident start never double-loads.
  assign fire = adv_q | start_i;

  // One-hot decodes; out-of-range indices decode to all zeros and so hit nothing.
  always_comb begin
    step_dec      = '0;
    edit_step_dec = '0;
    for (int s = 0; s < STEPS; s++) begin
      step_dec[s]      = (step_i == STEP_W'(s));
      edit_step_dec[s] = (edit_step_i == STEP_W'(s));
    end
  end

  always_comb begin
    edit_trk_dec = '0;
    toggle_mask  = '0;
    for (int t = 0; t < TRACKS; t++) begin
      edit_trk_dec[t] = (edit_track_i == TRK_W'(t));
      toggle_mask[t]  = edit_trk_dec[t] ? edit_step_dec : '0;
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    if (edit_clear_i) begin
      pattern_d = '0;
    end else if (edit_toggle_i) begin
      pattern_d = pattern_q ^ toggle_mask;
    end
  end

  // Trigger decisions read pattern_q, i.e. the value before any same-cycle edit.
  always_comb begin
    load    = '0;
    timer_d = timer_q;
    for (int t = 0; t < TRACKS; t++) begin
      load[t] = fire && (|(pattern_q[t] & step_dec)) && !mute_i[t];
      if (load[t]) begin
        timer_d[t] = TMR_LOAD;
      end else if (timer_q[t] != '0) begin
        timer_d[t] = timer_q[t] - TMR_ONE;
      end
    end
  end

  assign beat_d = fire & step_dec[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adv_q     <= 1'b0;
      beat_q    <= 1'b0;
      pattern_q <= '0;
      timer_q   <= '0;
    end else begin
      adv_q     <= ~step_adv_i_n;
      beat_q    <= beat_d;
      pattern_q <= pattern_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    trig_o = '0;
    for (int t = 0; t < TRACKS; t++) begin
      trig_o[t] = (timer_q[t] != '0);
    end
  end

  always_comb begin
    row_o = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (edit_trk_dec[t]) begin
        row_o = pattern_q[t];
      end
    end
  end

  assign beat_o = beat_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench for drum_step_sequencer: a cycle table for editing and firing,
// then hand sequences for wrap/beat, reload, mute, edit collisions, start and reset.
module tb_drum_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] step_i;
  logic       step_adv_i_n;
  logic       start_i;
  logic [3:0] mute_i;
  logic [1:0] edit_track_i;
  logic [2:0] edit_step_i;
  logic       edit_toggle_i;
  logic       edit_clear_i;
  logic [3:0] trig_o;
  logic       beat_o;
  logic [7:0] row_o;

  int n_tests = 0;
  int n_fail  = 0;

  drum_step_sequencer #(
    .TRACKS(4), .STEPS(8), .STEP_W(3), .TRK_W(2), .TRIG_LEN(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step_i       (step_i),
    .step_adv_i_n (step_adv_i_n),
    .start_i      (start_i),
    .mute_i       (mute_i),
    .edit_track_i (edit_track_i),
    .edit_step_i  (edit_step_i),
    .edit_toggle_i(edit_toggle_i),
    .edit_clear_i (edit_clear_i),
    .trig_o       (trig_o),
    .beat_o       (beat_o),
    .row_o        (row_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       adv_n;
    logic [2:0] step;
    logic [1:0] etrk;
    logic [2:0] estep;
    logic       tog;
    logic [3:0] exp_trig;
    logic       exp_beat;
    logic [7:0] exp_row;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [1:0] t, input logic [2:0] s);
    edit_track_i  = t;
    edit_step_i   = s;
    edit_toggle_i = 1'b1;
    cyc();
    edit_toggle_i = 1'b0;
  endtask

  task automatic clear_all();
    edit_clear_i = 1'b1;
    cyc();
    edit_clear_i = 1'b0;
  endtask

  // Strobe cycle; afterwards the counter shows nxt and the following edge is the fire edge.
  task automatic strobe(input logic [2:0] nxt);
    step_adv_i_n = 1'b0;
    cyc();
    step_adv_i_n = 1'b1;
    step_i       = nxt;
  endtask

  initial begin
    int cur_step;
    int hi, first, beats, total_beats;
    logic [2:0] nxt;
    logic hit;

    step_i = 3'd0; step_adv_i_n = 1'b1; start_i = 1'b0; mute_i = 4'b0;
    edit_track_i = 2'd0; edit_step_i = 3'd0; edit_toggle_i = 1'b0; edit_clear_i = 1'b0;

    // Async reset must clear outputs before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_trig", 32'(trig_o), 32'h0);
    chk("reset_beat", 32'(beat_o), 32'h0);
    chk("reset_row", 32'(row_o), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();

    vecs[0]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b1, 4'b0000, 1'b0, 8'h01};
    vecs[1]  = '{1'b1, 3'd0, 2'd0, 3'd4, 1'b1, 4'b0000, 1'b0, 8'h11};
    vecs[2]  = '{1'b1, 3'd0, 2'd1, 3'd2, 1'b1, 4'b0000, 1'b0, 8'h04};
    vecs[3]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[4]  = '{1'b0, 3'd7, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[5]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b1, 8'h11};
    vecs[6]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 8'h11};
    vecs[7]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 8'h11};
    vecs[8]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 8'h11};
    vecs[9]  = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[10] = '{1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[11] = '{1'b1, 3'd1, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 3'd1, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[13] = '{1'b1, 3'd2, 2'd0, 3'd0, 1'b0, 4'b0010, 1'b0, 8'h11};
    vecs[14] = '{1'b1, 3'd2, 2'd0, 3'd0, 1'b0, 4'b0010, 1'b0, 8'h11};
    vecs[15] = '{1'b0, 3'd2, 2'd0, 3'd0, 1'b0, 4'b0010, 1'b0, 8'h11};
    vecs[16] = '{1'b1, 3'd3, 2'd0, 3'd0, 1'b0, 4'b0010, 1'b0, 8'h11};
    vecs[17] = '{1'b0, 3'd3, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 8'h11};
    vecs[18] = '{1'b1, 3'd4, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 8'h11};
    vecs[19] = '{1'b1, 3'd4, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 8'h11};

    for (int i = 0; i < 20; i++) begin
      step_adv_i_n  = vecs[i].adv_n;
      step_i        = vecs[i].step;
      edit_track_i  = vecs[i].etrk;
      edit_step_i   = vecs[i].estep;
      edit_toggle_i = vecs[i].tog;
      cyc();
      chk($sformatf("vec%0d_trig", i), 32'(trig_o), 32'(vecs[i].exp_trig));
      chk($sformatf("vec%0d_beat", i), 32'(beat_o), 32'(vecs[i].exp_beat));
      chk($sformatf("vec%0d_row", i), 32'(row_o), 32'(vecs[i].exp_row));
    end
    edit_toggle_i = 1'b0;
    repeat (4) cyc();

    // Counter n=8, strobe every 16 cycles; track 0 holds steps 0 and 4.
    cur_step = 4;
    total_beats = 0;
    for (int k = 0; k < 16; k++) begin
      nxt = 3'((cur_step + 1) % 8);
      cur_step = int'(nxt);
      hit = (nxt == 3'd0) || (nxt == 3'd4);
      strobe(nxt);
      hi = 0; first = 0; beats = 0;
      for (int c = 1; c <= 15; c++) begin
        cyc();
        if (trig_o[0]) begin
          hi++;
          if (first == 0) first = c;
        end
        if (beat_o) beats++;
      end
      total_beats += beats;
      chk($sformatf("seq%0d_len", k), 32'(hi), hit ? 32'd4 : 32'd0);
      chk($sformatf("seq%0d_rise", k), 32'(first), hit ? 32'd1 : 32'd0);
      chk($sformatf("seq%0d_beat", k), 32'(beats), (nxt == 3'd0) ? 32'd1 : 32'd0);
    end
    chk("seq_total_beats", 32'(total_beats), 32'd2);

    // Track 1 on all steps, strobe every 2 cycles: continuous reload.
    clear_all();
    for (int s = 0; s < 8; s++) toggle(2'd1, 3'(s));
    edit_track_i = 2'd1;
    #1;
    chk("all_steps_row", 32'(row_o), 32'hFF);
    for (int k = 0; k < 8; k++) begin
      strobe(3'(k));
      if (k > 0) chk($sformatf("reload%0d_adv", k), 32'(trig_o), 32'b0010);
      cyc();
      chk($sformatf("reload%0d_fire", k), 32'(trig_o), 32'b0010);
    end
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("reload_tail%0d", c), 32'(trig_o), (c < 4) ? 32'b0010 : 32'b0000);
    end

    // Mute during an active pulse lets it finish but blocks later loads.
    clear_all();
    toggle(2'd2, 3'd0);
    toggle(2'd2, 3'd1);
    toggle(2'd2, 3'd3);
    strobe(3'd0);
    cyc();
    chk("mute_pre_load", 32'(trig_o), 32'b0100);
    mute_i = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("mute_finish%0d", c), 32'(trig_o), (c < 4) ? 32'b0100 : 32'b0000);
    end
    strobe(3'd1);
    cyc();
    chk("mute_block_a", 32'(trig_o), 32'b0000);
    cyc();
    chk("mute_block_b", 32'(trig_o), 32'b0000);
    mute_i = 4'b0000;
    strobe(3'd3);
    cyc();
    chk("unmute_load", 32'(trig_o), 32'b0100);
    repeat (4) cyc();

    // Toggle and fire on the same bit: decision uses the old bit.
    clear_all();
    toggle(2'd0, 3'd5);
    edit_track_i = 2'd0;
    #1;
    chk("tf_row_pre", 32'(row_o), 32'h20);
    strobe(3'd5);
    edit_step_i = 3'd5; edit_toggle_i = 1'b1;
    cyc();
    edit_toggle_i = 1'b0;
    chk("tf_old_one_trig", 32'(trig_o[0]), 32'd1);
    chk("tf_old_one_row", 32'(row_o), 32'h00);
    repeat (4) cyc();
    strobe(3'd5);
    edit_step_i = 3'd5; edit_toggle_i = 1'b1;
    cyc();
    edit_toggle_i = 1'b0;
    chk("tf_old_zero_trig", 32'(trig_o[0]), 32'd0);
    chk("tf_old_zero_row", 32'(row_o), 32'h20);

    // Clear beats toggle; clear with fire still fires from the old pattern.
    clear_all();
    toggle(2'd0, 3'd1);
    #1;
    chk("ct_row_pre", 32'(row_o), 32'h02);
    edit_step_i = 3'd3; edit_toggle_i = 1'b1; edit_clear_i = 1'b1;
    cyc();
    edit_toggle_i = 1'b0; edit_clear_i = 1'b0;
    chk("ct_row", 32'(row_o), 32'h00);
    toggle(2'd0, 3'd6);
    strobe(3'd6);
    edit_clear_i = 1'b1;
    cyc();
    edit_clear_i = 1'b0;
    chk("cf_trig", 32'(trig_o[0]), 32'd1);
    chk("cf_row", 32'(row_o), 32'h00);
    repeat (4) cyc();

    // start_i fires the held step immediately.
    clear_all();
    toggle(2'd3, 3'd0);
    edit_track_i = 2'd3;
    step_i = 3'd0;
    cyc();
    chk("start_idle_trig", 32'(trig_o), 32'b0000);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("start_trig", 32'(trig_o), 32'b1000);
    chk("start_beat", 32'(beat_o), 32'd1);
    cyc();
    chk("start_beat_once", 32'(beat_o), 32'd0);
    chk("start_trig_hold", 32'(trig_o), 32'b1000);
    repeat (3) cyc();
    chk("start_trig_end", 32'(trig_o), 32'b0000);

    // start_i coincident with adv_q is a single fire.
    step_adv_i_n = 1'b0;
    cyc();
    step_adv_i_n = 1'b1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    hi = 0; beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      if (trig_o[3]) hi++;
      if (beat_o) beats++;
    end
    chk("start_adv_len", 32'(hi), 32'd4);
    chk("start_adv_beat", 32'(beats), 32'd1);

    // Reset mid-pulse kills outputs without waiting for a clock edge.
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("rst_pre_beat", 32'(beat_o), 32'd1);
    chk("rst_pre_row", 32'(row_o), 32'h01);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_trig", 32'(trig_o), 32'h0);
    chk("rst_mid_beat", 32'(beat_o), 32'h0);
    chk("rst_mid_row", 32'(row_o), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    chk("rst_after_trig", 32'(trig_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
